// File: rtl/bounce_generator.sv
// Mechanical-switch emulator: turns a clean requested level into a contact-bounce
// waveform with LFSR-spaced edges, then settles and pulses done.
//
// state  | meaning
// IDLE   | out equals the settled level, waiting for level_in to differ
// BOUNCE | bounce window running, out toggles whenever the dwell timer expires
module bounce_generator #(
   parameter int          BOUNCE_CYCLES = 500000,
   parameter int          MIN_DWELL     = 1000,
   parameter int          DWELL_BITS    = 14,
   parameter logic [15:0] SEED          = 16'hACE1
) (
   input  logic CLK50MHZ,
   input  logic RST,
   input  logic level_in,
   output logic out,
   output logic busy,
   output logic done
);

   localparam int          WIN_W    = $clog2(BOUNCE_CYCLES + 1);
   localparam int          DWELL_W  = $clog2(MIN_DWELL + (1 << DWELL_BITS));
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam logic [WIN_W-1:0]   WIN_LOAD  = WIN_W'(BOUNCE_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_MIN = DWELL_W'(MIN_DWELL);

   typedef enum logic {IDLE, BOUNCE} state_t;

   state_t             state, state_nxt;
   logic               out_nxt, busy_nxt, done_nxt;
   logic               stable, stable_nxt;
   logic               target, target_nxt;
   logic [15:0]        lfsr, lfsr_nxt, lfsr_step;
   logic [WIN_W-1:0]   win, win_nxt;
   logic [DWELL_W-1:0] dwell, dwell_nxt;

   // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
   assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   function automatic logic [DWELL_W-1:0] dwell_load(input logic [15:0] l);
      return DWELL_MIN + DWELL_W'(l[DWELL_BITS-1:0]);
   endfunction

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         state  <= IDLE;
         out    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         stable <= 1'b0;
         target <= 1'b0;
         lfsr   <= SEED_EFF;
         win    <= '0;
         dwell  <= '0;
      end else begin
         state  <= state_nxt;
         out    <= out_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         stable <= stable_nxt;
         target <= target_nxt;
         lfsr   <= lfsr_nxt;
         win    <= win_nxt;
         dwell  <= dwell_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      out_nxt    = out;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      stable_nxt = stable;
      target_nxt = target;
      lfsr_nxt   = lfsr;
      win_nxt    = win;
      dwell_nxt  = dwell;
      case (state)
         IDLE: begin
            if (level_in != stable) begin
               // out equals stable here, so the first edge is always the contact make
               target_nxt = level_in;
               win_nxt    = WIN_LOAD;
               dwell_nxt  = dwell_load(lfsr);
               out_nxt    = ~out;
               busy_nxt   = 1'b1;
               state_nxt  = BOUNCE;
            end
         end
         BOUNCE: begin
            if (level_in != target) begin
               // a new request restarts the window; the dwell timer pauses for this cycle
               target_nxt = level_in;
               win_nxt    = WIN_LOAD;
            end else if (win == WIN_W'(1)) begin
               out_nxt    = target;
               stable_nxt = target;
               done_nxt   = 1'b1;
               busy_nxt   = 1'b0;
               state_nxt  = IDLE;
            end else begin
               win_nxt = win - WIN_W'(1);
               if (dwell == '0) begin
                  out_nxt   = ~out;
                  lfsr_nxt  = lfsr_step;
                  dwell_nxt = dwell_load(lfsr_step);
               end else begin
                  dwell_nxt = dwell - DWELL_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: event-time reference model checked every cycle,
// plus directed press/release/restart/reset/repeatability scenarios.
module tb_bounce_generator;

   localparam int          B    = 200;
   localparam int          MIND = 4;
   localparam int          DB   = 3;
   localparam logic [15:0] SEED = 16'h1234;
   localparam int          DB_N = B + 10;

   logic CLK50MHZ = 1'b0;
   logic RST      = 1'b1;
   logic level_in = 1'b0;
   logic out, busy, done;

   bounce_generator #(.BOUNCE_CYCLES(B), .MIN_DWELL(MIND), .DWELL_BITS(DB), .SEED(SEED)) dut (
      .CLK50MHZ(CLK50MHZ), .RST(RST), .level_in(level_in),
      .out(out), .busy(busy), .done(done)
   );

   always #10 CLK50MHZ = ~CLK50MHZ;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: absolute edge times for the next toggle and the settle point
   bit          m_valid = 0;
   bit          m_out, m_busy, m_done, m_stable, m_target;
   logic [15:0] m_lfsr;
   int          settle_at, toggle_at;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic int gap_of(input logic [15:0] l);
      return MIND + int'(l & 16'((1 << DB) - 1)) + 1;
   endfunction

   always @(posedge CLK50MHZ) begin
      cyc++;
      if (RST) begin
         m_valid = 1; m_out = 0; m_busy = 0; m_done = 0;
         m_stable = 0; m_target = 0; m_lfsr = SEED;
      end else if (m_valid) begin
         m_done = 0;
         if (!m_busy) begin
            if (level_in != m_stable) begin
               m_target  = level_in;
               settle_at = cyc + B;
               toggle_at = cyc + gap_of(m_lfsr);
               m_out     = ~m_out;
               m_busy    = 1;
            end
         end else if (level_in != m_target) begin
            m_target  = level_in;
            settle_at = cyc + B;
            toggle_at = toggle_at + 1;
         end else if (cyc == settle_at) begin
            m_out = m_target; m_stable = m_target; m_done = 1; m_busy = 0;
         end else if (cyc == toggle_at) begin
            m_out     = ~m_out;
            m_lfsr    = lfsr_next(m_lfsr);
            toggle_at = cyc + gap_of(m_lfsr);
         end
      end
   end

   always @(negedge CLK50MHZ) begin
      if (m_valid) begin
         check("model_out",  int'(out),  int'(m_out));
         check("model_busy", int'(busy), int'(m_busy));
         check("model_done", int'(done), int'(m_done));
      end
   end

   // Downstream debouncer fed from out: accepts a level after DB_N steady cycles
   int db_cnt = 0, db_pulses = 0;
   bit db_level = 0;
   always @(negedge CLK50MHZ) begin
      if (RST) begin
         db_cnt = 0; db_level = 0;
      end else if (out == db_level) begin
         db_cnt = 0;
      end else begin
         db_cnt++;
         if (db_cnt >= DB_N) begin
            db_level = out; db_cnt = 0;
            if (out) db_pulses++;
         end
      end
   end

   task automatic tick();
      @(posedge CLK50MHZ);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick(); tick();
      RST = 1'b0;
   endtask

   // Press, record the bounce, hold, release; returns debounced press pulses seen
   task automatic press_run(output bit tr[260], output int pulses);
      int p0;
      p0 = db_pulses;
      level_in = 1'b0;
      repeat (5) tick();
      level_in = 1'b1;
      for (int i = 0; i < 260; i++) begin
         tick();
         tr[i] = out;
      end
      repeat (300) tick();
      level_in = 1'b0;
      repeat (600) tick();
      pulses = db_pulses - p0;
   endtask

   bit trace1[260], trace2[260];

   initial begin
      int  ntog, last, gap_bad, dones, diffs, p1, p2;
      bit  prev, moved, busy_drop;

      // 1: reset and quiet idle
      RST = 1'b1; level_in = 1'b0;
      repeat (3) tick();
      check("reset_out", int'(out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      RST = 1'b0;
      moved = 0;
      repeat (100) begin
         tick();
         if (out || busy || done) moved = 1;
      end
      check("idle_quiet", int'(moved), 0);

      // 2: press with gap bounds and exact latency
      level_in = 1'b1;
      tick();
      check("press_first_edge", int'(out), 1);
      check("press_busy", int'(busy), 1);
      prev = out; last = 0; ntog = 0; gap_bad = 0; busy_drop = 0;
      for (int k = 1; k < B; k++) begin
         tick();
         if (!busy || done) busy_drop = 1;
         if (out != prev) begin
            if (k - last < MIND + 1 || k - last > MIND + (1 << DB)) gap_bad++;
            last = k; ntog++;
         end
         prev = out;
      end
      check("press_busy_window", int'(busy_drop), 0);
      check("press_gap_range", gap_bad, 0);
      check("press_toggle_count_ge16", int'(ntog >= 16), 1);
      tick();
      check("press_settle_out", int'(out), 1);
      check("press_settle_done", int'(done), 1);
      check("press_settle_busy", int'(busy), 0);
      tick();
      check("press_done_low", int'(done), 0);

      // 3: release
      level_in = 1'b0;
      tick();
      check("release_first_edge", int'(out), 0);
      dones = 0;
      for (int k = 1; k <= B + 20; k++) begin
         tick();
         if (done) begin
            dones++;
            check("release_done_time", k, B);
         end
      end
      check("release_one_done", dones, 1);
      check("release_final", int'(out), 0);

      // 4: mid-bounce return to the original level restarts the window
      level_in = 1'b1;
      tick();
      repeat (49) tick();
      level_in = 1'b0;
      tick();
      busy_drop = 0;
      repeat (B - 1) begin
         tick();
         if (!busy || done) busy_drop = 1;
      end
      check("restart_busy_held", int'(busy_drop), 0);
      tick();
      check("restart_done", int'(done), 1);
      check("restart_out", int'(out), 0);
      moved = 0;
      repeat (20) begin
         tick();
         if (busy || out) moved = 1;
      end
      check("restart_stable_unchanged", int'(moved), 0);

      // 5: reset mid-bounce aborts without a done pulse
      level_in = 1'b1;
      tick();
      repeat (99) tick();
      RST = 1'b1; level_in = 1'b0;
      tick();
      check("abort_out", int'(out), 0);
      check("abort_busy", int'(busy), 0);
      RST = 1'b0;
      dones = 0;
      repeat (300) begin
         tick();
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);

      // random level activity, including changes inside the window
      for (int i = 0; i < 60; i++) begin
         level_in = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 350)) tick();
      end
      level_in = 1'b0;
      repeat (B + 50) tick();

      // 6: repeatability after reset and debounced loopback
      do_reset();
      press_run(trace1, p1);
      do_reset();
      press_run(trace2, p2);
      diffs = 0;
      for (int i = 0; i < 260; i++) if (trace1[i] != trace2[i]) diffs++;
      check("repeat_trace_diffs", diffs, 0);
      check("loopback_pulses_run1", p1, 1);
      check("loopback_pulses_run2", p2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
